// File: rtl/score_engine_mlane_pkg.sv
// Shared judgement codes, default point values and the combo-band multiplier rule.
package score_engine_mlane_pkg;

    localparam logic [1:0] JUDGE_NONE    = 2'b00;
    localparam logic [1:0] JUDGE_MISS    = 2'b01;
    localparam logic [1:0] JUDGE_GOOD    = 2'b10;
    localparam logic [1:0] JUDGE_PERFECT = 2'b11;

    localparam int PTS_GOOD_DEF    = 2;
    localparam int PTS_PERFECT_DEF = 4;

    // One multiplier step per band of 2^shift combo, clamped at max_mult.
    function automatic int band_mult(input int combo_pre, input int shift, input int max_mult);
        int m;
        m = 1 + (combo_pre >>> shift);
        return (m > max_mult) ? max_mult : m;
    endfunction

endpackage

// File: rtl/score_sat_acc.sv
// Saturating accumulator: value <= min(value + add, max) when en; sticky sat flag, one-cycle upd on change.
// Latency: 1 edge from en to value; no backpressure, accepts an add every cycle.
module score_sat_acc #(
    parameter int W     = 16,
    parameter int ADD_W = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [ADD_W-1:0] add,
    output logic [W-1:0]     value,
    output logic             upd,
    output logic             sat
);

    localparam int SW = ((W > ADD_W) ? W : ADD_W) + 1;

    logic [SW-1:0] sum;
    logic          ovf;
    logic [W-1:0]  nxt;

    always_comb begin
        sum = SW'(value) + SW'(add);
        ovf = sum > SW'({W{1'b1}});
        nxt = ovf ? '1 : sum[W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
            upd   <= 1'b0;
            sat   <= 1'b0;
        end else if (clr) begin
            value <= '0;
            upd   <= 1'b0;
            sat   <= 1'b0;
        end else if (en) begin
            value <= nxt;
            upd   <= (nxt != value);
            sat   <= sat | ovf;
        end else begin
            upd   <= 1'b0;
        end
    end

endmodule

// File: rtl/score_engine_mlane.sv
// Multi-lane score engine: lane decode, combo tracking, banded multiplier, saturating score.
// Latency: combo/multiplier 1 edge, score 2 edges after acceptance; no backpressure, one event per cycle.
module score_engine_mlane
    import score_engine_mlane_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int PTS_GOOD    = PTS_GOOD_DEF,
    parameter int PTS_PERFECT = PTS_PERFECT_DEF,
    parameter int BAND_SHIFT  = 4,
    parameter int MAX_MULT    = 17
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 evt_valid,
    input  logic [2*LANES-1:0]   judge,
    input  logic                 clear,
    input  logic                 freeze,
    output logic [SCORE_W-1:0]   score,
    output logic                 score_upd,
    output logic                 score_sat,
    output logic [COMBO_W-1:0]   combo,
    output logic [COMBO_W-1:0]   max_combo,
    output logic [4:0]           multiplier
);

    localparam int BASE_W = $clog2(LANES*PTS_PERFECT+1);
    localparam int PROD_W = $clog2(LANES*PTS_PERFECT*MAX_MULT+1);
    localparam int HIT_W  = $clog2(LANES+1);

    logic [BASE_W-1:0]  base_nxt;
    logic [BASE_W-1:0]  s1_base;
    logic [HIT_W-1:0]   hits;
    logic               any_miss;
    logic [COMBO_W:0]   combo_sum;
    logic [COMBO_W-1:0] combo_nxt;
    logic [4:0]         mult_nxt;
    logic               accept;
    logic               s1_vld;
    logic [PROD_W-1:0]  prod;

    always_comb begin
        base_nxt = '0;
        hits     = '0;
        any_miss = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            case (judge[2*i +: 2])
                JUDGE_NONE:    ;
                JUDGE_MISS:    any_miss = 1'b1;
                JUDGE_GOOD: begin
                    base_nxt = base_nxt + BASE_W'(PTS_GOOD);
                    hits     = hits + HIT_W'(1);
                end
                JUDGE_PERFECT: begin
                    base_nxt = base_nxt + BASE_W'(PTS_PERFECT);
                    hits     = hits + HIT_W'(1);
                end
            endcase
        end
    end

    // Multiplier is banded on the combo held before this event.
    always_comb begin
        combo_sum = {1'b0, combo} + (COMBO_W+1)'(hits);
        if (any_miss)
            combo_nxt = '0;
        else if (combo_sum[COMBO_W])
            combo_nxt = '1;
        else
            combo_nxt = combo_sum[COMBO_W-1:0];
        mult_nxt = 5'(band_mult(int'(combo), BAND_SHIFT, MAX_MULT));
        accept   = evt_valid && !freeze && !clear;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld     <= 1'b0;
            s1_base    <= '0;
            combo      <= '0;
            max_combo  <= '0;
            multiplier <= 5'd1;
        end else if (clear) begin
            s1_vld     <= 1'b0;
            s1_base    <= '0;
            combo      <= '0;
            max_combo  <= '0;
            multiplier <= 5'd1;
        end else if (accept) begin
            s1_vld     <= 1'b1;
            s1_base    <= base_nxt;
            combo      <= combo_nxt;
            max_combo  <= (combo_nxt > max_combo) ? combo_nxt : max_combo;
            multiplier <= mult_nxt;
        end else begin
            s1_vld     <= 1'b0;
        end
    end

    assign prod = PROD_W'(s1_base) * PROD_W'(multiplier);

    score_sat_acc #(
        .W     (SCORE_W),
        .ADD_W (PROD_W)
    ) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (s1_vld),
        .clr     (clear),
        .add     (prod),
        .value   (score),
        .upd     (score_upd),
        .sat     (score_sat)
    );

endmodule

// File: tb/tb_score_engine_mlane.sv
// Bench for score_engine_mlane: constant-table vectors, directed corner sequences and a randomized
// run checked every cycle against an event-queue reference model (16-bit and 8-bit score builds).
module tb_score_engine_mlane;

    localparam int LANES = 4;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic        evt_valid = 1'b0;
    logic        clear     = 1'b0;
    logic        freeze    = 1'b0;
    logic [7:0]  judge     = 8'h00;

    logic [15:0] score;
    logic        score_upd, score_sat;
    logic [7:0]  combo, max_combo;
    logic [4:0]  multiplier;

    logic [7:0]  score8;
    logic        score_upd8, score_sat8;
    logic [7:0]  combo8, max_combo8;
    logic [4:0]  multiplier8;

    always #5 clk = ~clk;

    score_engine_mlane dut (
        .clk(clk), .reset_n(reset_n), .evt_valid(evt_valid), .judge(judge),
        .clear(clear), .freeze(freeze), .score(score), .score_upd(score_upd),
        .score_sat(score_sat), .combo(combo), .max_combo(max_combo), .multiplier(multiplier)
    );

    score_engine_mlane #(.SCORE_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .evt_valid(evt_valid), .judge(judge),
        .clear(clear), .freeze(freeze), .score(score8), .score_upd(score_upd8),
        .score_sat(score_sat8), .combo(combo8), .max_combo(max_combo8), .multiplier(multiplier8)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: points of an accepted event land in score one edge after acceptance.
    typedef struct { longint due; int pts; } pend_t;
    pend_t  pq[$];
    longint edge_n = 0;
    int     m_score[2];
    bit     m_upd[2];
    bit     m_sat[2];
    int     m_combo, m_max, m_mult;
    int     smax[2] = '{65535, 255};

    task automatic model_reset();
        pq.delete();
        for (int k = 0; k < 2; k++) begin
            m_score[k] = 0;
            m_upd[k]   = 1'b0;
            m_sat[k]   = 1'b0;
        end
        m_combo = 0;
        m_max   = 0;
        m_mult  = 1;
    endtask

    task automatic model_edge();
        int    base, hits, total, ns;
        bit    miss;
        pend_t p;
        edge_n++;
        m_upd[0] = 1'b0;
        m_upd[1] = 1'b0;
        if (clear) begin
            model_reset();
            return;
        end
        while (pq.size() > 0 && pq[0].due == edge_n) begin
            p = pq.pop_front();
            for (int k = 0; k < 2; k++) begin
                total = m_score[k] + p.pts;
                ns    = (total > smax[k]) ? smax[k] : total;
                if (total > smax[k]) m_sat[k] = 1'b1;
                m_upd[k]   = (ns != m_score[k]);
                m_score[k] = ns;
            end
        end
        if (evt_valid && !freeze) begin
            base = 0; hits = 0; miss = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                case (judge[2*i +: 2])
                    2'd1: miss = 1'b1;
                    2'd2: begin base += 2; hits++; end
                    2'd3: begin base += 4; hits++; end
                    default: ;
                endcase
            end
            m_mult = 1 + m_combo / 16;
            if (m_mult > 17) m_mult = 17;
            m_combo = miss ? 0 : ((m_combo + hits > 255) ? 255 : m_combo + hits);
            if (m_combo > m_max) m_max = m_combo;
            pq.push_back('{due: edge_n + 1, pts: base * m_mult});
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_edge();
    end

    always @(negedge clk) begin
        chk("model score",      32'(score),      32'(m_score[0]));
        chk("model score_upd",  32'(score_upd),  32'(m_upd[0]));
        chk("model score_sat",  32'(score_sat),  32'(m_sat[0]));
        chk("model combo",      32'(combo),      32'(m_combo));
        chk("model max_combo",  32'(max_combo),  32'(m_max));
        chk("model multiplier", 32'(multiplier), 32'(m_mult));
        chk("model8 score",     32'(score8),     32'(m_score[1]));
        chk("model8 score_upd", 32'(score_upd8), 32'(m_upd[1]));
        chk("model8 score_sat", 32'(score_sat8), 32'(m_sat[1]));
        chk("model8 combo",     32'(combo8),     32'(m_combo));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic evt(input logic [7:0] j);
        evt_valid = 1'b1;
        judge     = j;
        cyc();
        evt_valid = 1'b0;
        judge     = 8'h00;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    function automatic logic [1:0] rand_code();
        int r;
        r = $urandom_range(0, 9);
        if (r < 1)      return 2'd1;
        else if (r < 4) return 2'd0;
        else if (r < 7) return 2'd2;
        else            return 2'd3;
    endfunction

    typedef struct {
        logic [7:0] j;
        int         exp_combo;
        int         exp_score;
        bit         exp_upd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{8'b11_11_10_01, 0, 10, 1'b1};
        tbl[1] = '{8'b00_00_00_11, 1,  4, 1'b1};
        tbl[2] = '{8'b10_10_10_10, 4,  8, 1'b1};
        tbl[3] = '{8'b11_11_11_11, 4, 16, 1'b1};
        tbl[4] = '{8'b00_00_00_00, 0,  0, 1'b0};
        tbl[5] = '{8'b01_00_00_00, 0,  0, 1'b0};
        tbl[6] = '{8'b11_10_00_11, 3, 10, 1'b1};

        #1 reset_n = 1'b0;
        cyc();
        cyc();
        chk("reset score",      32'(score),      0);
        chk("reset score_upd",  32'(score_upd),  0);
        chk("reset score_sat",  32'(score_sat),  0);
        chk("reset combo",      32'(combo),      0);
        chk("reset max_combo",  32'(max_combo),  0);
        chk("reset multiplier", 32'(multiplier), 1);
        reset_n = 1'b1;
        cyc();

        // Single events from a fresh game.
        for (int i = 0; i < 7; i++) begin
            do_clear();
            evt(tbl[i].j);
            chk("tbl combo",      32'(combo),      32'(tbl[i].exp_combo));
            chk("tbl multiplier", 32'(multiplier), 1);
            cyc();
            chk("tbl score",      32'(score),      32'(tbl[i].exp_score));
            chk("tbl score_upd",  32'(score_upd),  32'(tbl[i].exp_upd));
            cyc();
            chk("tbl upd drop",   32'(score_upd),  0);
        end

        // Band edge: 16 back-to-back lane0 perfects at mult 1, the 17th at mult 2.
        do_clear();
        evt_valid = 1'b1;
        judge     = 8'h03;
        repeat (16) cyc();
        evt_valid = 1'b0;
        cyc();
        chk("band score16", 32'(score), 64);
        chk("band combo16", 32'(combo), 16);
        evt(8'h03);
        chk("band combo17", 32'(combo),      17);
        chk("band mult17",  32'(multiplier), 2);
        cyc();
        chk("band score17", 32'(score),      72);
        chk("band upd17",   32'(score_upd),  1);

        // Back-to-back all-perfect events crossing into band 1.
        do_clear();
        evt_valid = 1'b1;
        judge     = 8'hFF;
        repeat (6) cyc();
        evt_valid = 1'b0;
        chk("b2b mult", 32'(multiplier), 2);
        cyc();
        chk("b2b score", 32'(score), 128);
        chk("b2b combo", 32'(combo), 24);

        // Saturation on the 8-bit build.
        do_clear();
        evt_valid = 1'b1;
        judge     = 8'hFF;
        repeat (20) cyc();
        evt_valid = 1'b0;
        cyc();
        chk("sat8 score", 32'(score8),     255);
        chk("sat8 flag",  32'(score_sat8), 1);
        chk("sat16 flag", 32'(score_sat),  0);
        evt(8'hFF);
        cyc();
        chk("sat8 hold",     32'(score8),     255);
        chk("sat8 no upd",   32'(score_upd8), 0);
        chk("sat8 sticky",   32'(score_sat8), 1);

        // Clear beats a same-cycle event and kills the one in flight.
        evt(8'hFF);
        clear     = 1'b1;
        evt_valid = 1'b1;
        judge     = 8'hFF;
        cyc();
        clear     = 1'b0;
        evt_valid = 1'b0;
        judge     = 8'h00;
        chk("clr score",     32'(score),      0);
        chk("clr combo",     32'(combo),      0);
        chk("clr max_combo", 32'(max_combo),  0);
        chk("clr mult",      32'(multiplier), 1);
        chk("clr sat8",      32'(score_sat8), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("clr no upd",   32'(score_upd), 0);
            chk("clr score0",   32'(score),     0);
        end

        // Freeze: in-flight event completes, frozen events dropped, max_combo kept.
        do_clear();
        evt(8'h03);
        evt(8'h03);
        evt(8'h03);
        evt(8'h01);
        evt(8'h03);
        freeze    = 1'b1;
        evt_valid = 1'b1;
        judge     = 8'hFF;
        repeat (3) cyc();
        chk("frz score", 32'(score),     16);
        chk("frz combo", 32'(combo),     1);
        chk("frz max",   32'(max_combo), 3);
        chk("frz mult",  32'(multiplier), 1);
        freeze    = 1'b0;
        evt_valid = 1'b0;
        judge     = 8'h00;
        cyc();

        // Randomized run against the reference model.
        for (int c = 0; c < 600; c++) begin
            reset_n   = ($urandom_range(0, 249) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            evt_valid = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < LANES; i++) judge[2*i +: 2] = rand_code();
            cyc();
        end
        reset_n   = 1'b1;
        clear     = 1'b0;
        freeze    = 1'b0;
        evt_valid = 1'b0;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
